// File: rtl/ifetch_resp_pkg.sv
// Shared widths, constants and the fetch bundle layout used by the instruction-fetch responder.
package ifetch_resp_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int REG_W       = 32;
  localparam int RDATA_W     = 64;

  localparam logic [REG_W-1:0] ZERO_WORD   = '0;
  localparam logic             CHIP_ENABLE = 1'b1;
  localparam logic             STOP        = 1'b1;
  localparam logic             NO_STOP     = 1'b0;

  // One buffered fetch: original PC (low bits kept) plus the aligned 64-bit memory word.
  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [RDATA_W-1:0]     rdata;
  } fetch_bundle_t;

  localparam int FETCH_BUNDLE_W = $bits(fetch_bundle_t);

  function automatic logic [INST_ADDR_W-1:0] align_addr(input logic [INST_ADDR_W-1:0] pc);
    return {pc[INST_ADDR_W-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/ifetch_resp_sync_fifo.sv
// Synchronous FIFO with show-ahead head, synchronous clear and push-while-full when popping.
module ifetch_resp_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= inc_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ifetch_resp.sv
// Instruction-fetch responder: issues aligned 64-bit reads, tracks in-flight PCs, buffers
// in-order responses and hands instruction pairs to decode, dropping stale fetches on flush.
module ifetch_resp
  import ifetch_resp_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INST_ADDR_W-1:0] pc_i,
  input  logic                   ce_i,
  input  logic                   flush_i,
  input  logic                   id_stall_i,
  output logic                   mem_req_o,
  output logic [INST_ADDR_W-1:0] mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [RDATA_W-1:0]     mem_rdata_i,
  output logic                   inst_valid_o,
  output logic [INST_ADDR_W-1:0] inst_pc_o,
  output logic [REG_W-1:0]       inst0_o,
  output logic [REG_W-1:0]       inst1_o,
  output logic [1:0]             slot_mask_o,
  output logic                   stallreq_o
);

  // Handshakes: a request transfers on mem_req_o & mem_gnt_i (pc_i/addr held until then);
  // mem_rvalid_i is a one-cycle pulse with no back-pressure, ordered like the grants;
  // a pair transfers to decode on inst_valid_o & ~id_stall_i.

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTST + 1);

  logic [OUT_W-1:0]       outst;
  logic [OUT_W-1:0]       drop;
  logic                   allowed;
  logic                   gnt_fire;
  logic                   rsp_fire;
  logic                   drop_fire;
  logic                   keep_fire;

  logic [INST_ADDR_W-1:0] tag_head;
  logic                   tag_full;
  logic                   tag_empty;
  logic [OUT_W-1:0]       tag_count;

  fetch_bundle_t          rsp_wdata;
  fetch_bundle_t          rsp_head;
  logic                   rsp_pop;
  logic                   rsp_full;
  logic                   rsp_empty;
  logic [CNT_W-1:0]       rsp_count;

  // Credit counts buffered entries plus every in-flight fetch, dropped ones included,
  // so an accepted response always finds room.
  assign allowed   = (int'(outst) < MAX_OUTST) && ((int'(rsp_count) + int'(outst)) < DEPTH);
  assign mem_req_o = rst && (ce_i == CHIP_ENABLE) && !flush_i && allowed;
  assign mem_addr_o = rst ? align_addr(pc_i) : ZERO_WORD;
  assign gnt_fire  = mem_req_o && mem_gnt_i;
  assign stallreq_o = (rst && (ce_i == CHIP_ENABLE) && !gnt_fire) ? STOP : NO_STOP;

  // Responses with nothing outstanding are ignored; the oldest 'drop' responses belong
  // to fetches cancelled by a flush and never touch the tag FIFO (it was cleared then).
  assign rsp_fire  = mem_rvalid_i && (outst != '0);
  assign drop_fire = rsp_fire && (drop != '0);
  assign keep_fire = rsp_fire && (drop == '0) && !flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outst <= '0;
      drop  <= '0;
    end else begin
      outst <= outst + OUT_W'(gnt_fire) - OUT_W'(rsp_fire);
      if (flush_i)        drop <= outst - OUT_W'(rsp_fire);
      else if (drop_fire) drop <= drop - OUT_W'(1);
    end
  end

  ifetch_resp_sync_fifo #(
    .WIDTH (INST_ADDR_W),
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (gnt_fire),
    .pop   (keep_fire),
    .clear (flush_i),
    .wdata (pc_i),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  assign rsp_wdata = '{pc: tag_head, rdata: mem_rdata_i};

  ifetch_resp_sync_fifo #(
    .WIDTH (FETCH_BUNDLE_W),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (keep_fire),
    .pop   (rsp_pop),
    .clear (flush_i),
    .wdata (rsp_wdata),
    .rdata (rsp_head),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_count)
  );

  assign inst_valid_o = !rsp_empty && !flush_i;
  assign rsp_pop      = inst_valid_o && !id_stall_i;
  assign inst_pc_o    = inst_valid_o ? rsp_head.pc : ZERO_WORD;
  assign inst0_o      = inst_valid_o ? rsp_head.rdata[31:0] : ZERO_WORD;
  assign inst1_o      = inst_valid_o ? rsp_head.rdata[63:32] : ZERO_WORD;
  assign slot_mask_o  = inst_valid_o ? {1'b1, ~rsp_head.pc[2]} : 2'b00;

  a_rvalid_with_outst: assert property (@(posedge clk) disable iff (!rst)
    mem_rvalid_i |-> (outst != '0));
  a_tag_room: assert property (@(posedge clk) disable iff (!rst)
    gnt_fire |-> !tag_full);
  a_tag_avail: assert property (@(posedge clk) disable iff (!rst)
    keep_fire |-> !tag_empty);
  a_tag_le_outst: assert property (@(posedge clk) disable iff (!rst)
    tag_count <= outst);
  a_rsp_room: assert property (@(posedge clk) disable iff (!rst)
    keep_fire |-> (!rsp_full || rsp_pop));

endmodule

// File: tb/tb_ifetch_resp.sv
// Bench for ifetch_resp: directed scenarios plus randomized traffic against a queue-level model.
module tb_ifetch_resp;

  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_i = '0;
  logic        ce_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        id_stall_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [63:0] mem_rdata_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_pc_o;
  logic [31:0] inst0_o;
  logic [31:0] inst1_o;
  logic [1:0]  slot_mask_o;
  logic        stallreq_o;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ifetch_resp #(
    .DEPTH     (DEPTH),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .ce_i         (ce_i),
    .flush_i      (flush_i),
    .id_stall_i   (id_stall_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_pc_o    (inst_pc_o),
    .inst0_o      (inst0_o),
    .inst1_o      (inst1_o),
    .slot_mask_o  (slot_mask_o),
    .stallreq_o   (stallreq_o)
  );

  // ---------------- model state ----------------
  typedef struct {
    logic [31:0] pc;
    logic [63:0] data;
    int          gcyc;
    bit          dropped;
  } flight_t;

  flight_t     inf_q[$];   // granted fetches not yet answered, oldest first
  logic [95:0] exp_q[$];   // {pc, rdata} pairs visible to decode, oldest first

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 2;
  bit          rand_rv = 1'b0;
  bit          rand_pc = 1'b0;
  bit          fixed_data = 1'b0;
  bit          last_valid = 1'b0;
  logic [31:0] cur_pc = '0;

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input bit ce, input bit flush, input bit stall, input bit gnt);
    bit          rv;
    bit          exp_req;
    bit          exp_valid;
    logic [95:0] head;
    logic [31:0] head_pc;
    flight_t     f;
    @(negedge clk);
    rv = 1'b0;
    if (inf_q.size() > 0 && cyc >= inf_q[0].gcyc + lat)
      rv = rand_rv ? ($urandom_range(0, 2) != 0) : 1'b1;
    ce_i         = ce;
    flush_i      = flush;
    id_stall_i   = stall;
    mem_gnt_i    = gnt;
    mem_rvalid_i = rv;
    mem_rdata_i  = rv ? inf_q[0].data : {$urandom(), $urandom()};
    pc_i         = cur_pc;
    #1;
    exp_req   = ce && !flush && (inf_q.size() < MAX_OUTST) &&
                (exp_q.size() + inf_q.size() < DEPTH);
    exp_valid = (exp_q.size() > 0) && !flush;
    head      = exp_valid ? exp_q[0] : 96'h0;
    head_pc   = head[95:64];
    chk("mem_req", mem_req_o, exp_req);
    chk("mem_addr", mem_addr_o, {cur_pc[31:3], 3'b000});
    chk("stallreq", stallreq_o, ce && !(exp_req && gnt));
    chk("inst_valid", inst_valid_o, exp_valid);
    chk("inst_pc", inst_pc_o, head_pc);
    chk("inst0", inst0_o, head[31:0]);
    chk("inst1", inst1_o, head[63:32]);
    chk("slot_mask", slot_mask_o, exp_valid ? {1'b1, ~head_pc[2]} : 2'b00);
    // advance the model to the state after the coming rising edge
    if (exp_valid && !stall) void'(exp_q.pop_front());
    if (rv) begin
      f = inf_q.pop_front();
      if (!f.dropped && !flush) exp_q.push_back({f.pc, f.data});
    end
    if (flush) begin
      exp_q.delete();
      foreach (inf_q[i]) inf_q[i].dropped = 1'b1;
    end
    if (exp_req && gnt) begin
      f.pc      = cur_pc;
      f.data    = fixed_data ? 64'h1111_2222_3333_4444 : {$urandom(), $urandom()};
      f.gcyc    = cyc;
      f.dropped = 1'b0;
      inf_q.push_back(f);
      cur_pc = rand_pc ? $urandom() : cur_pc + 32'd8;
    end
    last_valid = exp_valid;
    cyc++;
  endtask

  task automatic wait_valid(input bit ce, input bit gnt, input int budget);
    for (int i = 0; i < budget; i++) begin
      cycle(ce, 1'b0, 1'b0, gnt);
      if (last_valid) break;
    end
    chk("wait_valid", inst_valid_o, 1'b1);
  endtask

  // Reset lands mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    mem_rvalid_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_stallreq", stallreq_o, 1'b0);
    chk("rst_inst_valid", inst_valid_o, 1'b0);
    chk("rst_inst_pc", inst_pc_o, 32'h0);
    chk("rst_inst0", inst0_o, 32'h0);
    chk("rst_inst1", inst1_o, 32'h0);
    chk("rst_slot_mask", slot_mask_o, 2'b00);
    ce_i = 1'b0; flush_i = 1'b0; mem_gnt_i = 1'b0; id_stall_i = 1'b0;
    inf_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    ce_i = 1'b1;
    do_reset();

    // pair from aligned pc 0 with fixed data
    fixed_data = 1'b1; lat = 2; cur_pc = 32'h0;
    wait_valid(1'b1, 1'b1, 10);
    chk("t1_inst0", inst0_o, 32'h3333_4444);
    chk("t1_inst1", inst1_o, 32'h1111_2222);
    chk("t1_inst_pc", inst_pc_o, 32'h0);
    chk("t1_slot_mask", slot_mask_o, 2'b11);
    fixed_data = 1'b0;

    // odd-word pc: address aligned, only the upper slot valid
    do_reset();
    cur_pc = 32'h104;
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t2_mem_addr", mem_addr_o, 32'h100);
    wait_valid(1'b1, 1'b0, 10);
    chk("t2_inst_pc", inst_pc_o, 32'h104);
    chk("t2_slot_mask", slot_mask_o, 2'b10);

    // decode stalled: credit must stop requests at DEPTH entries
    do_reset();
    cur_pc = 32'h0;
    repeat (12) cycle(1'b1, 1'b0, 1'b1, 1'b1);
    chk("t3_req_blocked", mem_req_o, 1'b0);
    chk("t3_stallreq", stallreq_o, 1'b1);
    chk("t3_valid", inst_valid_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3_order_pc", inst_pc_o, 32'(i * 8));
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_drained", inst_valid_o, 1'b0);

    // flush with two fetches in flight, then redirect to 0x80
    do_reset();
    lat = 5; cur_pc = 32'h40;
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cur_pc = 32'h80;
    wait_valid(1'b1, 1'b1, 30);
    chk("t4_inst_pc", inst_pc_o, 32'h80);

    // grant withheld for three cycles
    do_reset();
    lat = 2; cur_pc = 32'h200;
    repeat (3) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t5_addr_stable", mem_addr_o, 32'h200);
      chk("t5_stallreq", stallreq_o, 1'b1);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    wait_valid(1'b1, 1'b0, 10);
    chk("t5_inst_pc", inst_pc_o, 32'h200);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_single_entry", inst_valid_o, 1'b0);

    // reset mid-burst with entries buffered and in flight, then clean restart
    do_reset();
    cur_pc = 32'h0;
    repeat (5) cycle(1'b1, 1'b0, 1'b1, 1'b1);
    chk("t6_buffered", inst_valid_o, 1'b1);
    do_reset();
    cur_pc = 32'h0;
    wait_valid(1'b1, 1'b1, 10);
    chk("t6_restart_pc", inst_pc_o, 32'h0);

    // randomized traffic
    do_reset();
    rand_rv = 1'b1; rand_pc = 1'b1; lat = 1; cur_pc = $urandom();
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 99) < 3,
            $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
